// File: rtl/audio_flt_pkg.sv
// -----------------------------------------------------------------------------
// audio_flt_pkg
// Shared types and constants for the audio filter control sequencer:
//   - sequencer state encoding and attenuation ramp modes
//   - filter coefficient record (flt_coef_t) and the preset table
//   - preset_field(): one coefficient field of one preset, zero-extended
// -----------------------------------------------------------------------------
package audio_flt_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_FADE_OUT = 3'd1,
        ST_LOAD     = 3'd2,
        ST_SETTLE   = 3'd3,
        ST_FADE_IN  = 3'd4
    } seq_state_t;

    // What the attenuation ramp does on its next tick.
    typedef enum logic [1:0] {
        RAMP_HOLD   = 2'd0,
        RAMP_TOWARD = 2'd1,
        RAMP_UP     = 2'd2
    } ramp_mode_t;

    localparam int         NUM_PRESETS = 4;
    localparam logic [4:0] ATT_MUTE    = 5'h10;
    localparam logic [4:0] ATT_MAX     = 5'h1F;

    typedef struct packed {
        logic [31:0] flt_rate;
        logic [39:0] cx;
        logic [7:0]  cx0;
        logic [7:0]  cx1;
        logic [7:0]  cx2;
        logic [23:0] cy0;
        logic [23:0] cy1;
        logic [23:0] cy2;
    } flt_coef_t;

    // Negative cy terms are stored as 24-bit two's complement.
    localparam flt_coef_t PRESET_0 = '{flt_rate: 32'd14112000, cx: 40'd480930,
                                       cx0: 8'd3, cx1: 8'd3, cx2: 8'd1,
                                       cy0: 24'd10523109, cy1: 24'd6217090, cy2: 24'd14717083};
    localparam flt_coef_t PRESET_1 = '{flt_rate: 32'd7056000, cx: 40'd120000,
                                       cx0: 8'd2, cx1: 8'd4, cx2: 8'd2,
                                       cy0: 24'd100, cy1: 24'd200, cy2: 24'd300};
    localparam flt_coef_t PRESET_2 = '{flt_rate: 32'd3528000, cx: 40'd60000,
                                       cx0: 8'd5, cx1: 8'd6, cx2: 8'd7,
                                       cy0: 24'd1000, cy1: 24'd2000, cy2: 24'd3000};
    localparam flt_coef_t PRESET_3 = '{flt_rate: 32'd1764000, cx: 40'd30000,
                                       cx0: 8'd8, cx1: 8'd9, cx2: 8'd10,
                                       cy0: 24'd11, cy1: 24'd22, cy2: 24'd33};

    // Preset lookup; any index outside the table falls back to preset 0.
    function automatic flt_coef_t preset_coef(input logic [3:0] idx);
        case (idx)
            4'd1:    preset_coef = PRESET_1;
            4'd2:    preset_coef = PRESET_2;
            4'd3:    preset_coef = PRESET_3;
            default: preset_coef = PRESET_0;
        endcase
    endfunction

    // Field order matches the LOAD write order: 0 flt_rate .. 7 cy2.
    function automatic logic [39:0] preset_field(input logic [3:0] idx, input logic [2:0] field);
        flt_coef_t c;
        c = preset_coef(idx);
        case (field)
            3'd0:    preset_field = {8'd0, c.flt_rate};
            3'd1:    preset_field = c.cx;
            3'd2:    preset_field = {32'd0, c.cx0};
            3'd3:    preset_field = {32'd0, c.cx1};
            3'd4:    preset_field = {32'd0, c.cx2};
            3'd5:    preset_field = {16'd0, c.cy0};
            3'd6:    preset_field = {16'd0, c.cy1};
            3'd7:    preset_field = {16'd0, c.cy2};
            default: preset_field = 40'd0;
        endcase
    endfunction

endpackage

// File: rtl/audio_flt_sequencer_if.sv
// -----------------------------------------------------------------------------
// audio_flt_sequencer_if
// Control requests into the sequencer and the applied filter settings out.
//   Requests : afilter_sw[3:0], vol_att[3:0], mix_sel[1:0], pause_core
//   Applied  : att[4:0], mix[1:0], flt_rate[31:0], cx[39:0], cx0..cx2[7:0],
//              cy0..cy2[23:0], busy, muted
// master = requester / consumer side, slave = the sequencer.
// -----------------------------------------------------------------------------
interface audio_flt_sequencer_if;
    logic [3:0]  afilter_sw;
    logic [3:0]  vol_att;
    logic [1:0]  mix_sel;
    logic        pause_core;

    logic [4:0]  att;
    logic [1:0]  mix;
    logic [31:0] flt_rate;
    logic [39:0] cx;
    logic [7:0]  cx0;
    logic [7:0]  cx1;
    logic [7:0]  cx2;
    logic [23:0] cy0;
    logic [23:0] cy1;
    logic [23:0] cy2;
    logic        busy;
    logic        muted;

    modport master (
        output afilter_sw, vol_att, mix_sel, pause_core,
        input  att, mix, flt_rate, cx, cx0, cx1, cx2, cy0, cy1, cy2, busy, muted
    );

    modport slave (
        input  afilter_sw, vol_att, mix_sel, pause_core,
        output att, mix, flt_rate, cx, cx0, cx1, cx2, cy0, cy1, cy2, busy, muted
    );
endinterface

// File: rtl/audio_flt_sequencer_att_ramp.sv
// -----------------------------------------------------------------------------
// att_ramp
// Attenuation ramp: free-running tick divider and a 5-bit attenuation register
// that moves at most one step per tick.
//   clk, reset : filter clock, synchronous active-high reset
//   i_mode     : HOLD / TOWARD target / UP toward ATT_MAX
//   i_tgt      : target attenuation for TOWARD
//   o_att      : current attenuation (resets muted)
// -----------------------------------------------------------------------------
module att_ramp
    import audio_flt_pkg::*;
#(
    parameter int RAMP_DIV = 256
) (
    input  logic       clk,
    input  logic       reset,
    input  ramp_mode_t i_mode,
    input  logic [4:0] i_tgt,
    output logic [4:0] o_att
);
    localparam int            CW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(RAMP_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic [4:0]    r_att;
    logic [4:0]    w_att_nxt;
    logic          w_tick;

    assign w_tick = (r_cnt == CNT_LAST);
    assign o_att  = r_att;

    // Tick divider: counts 0..RAMP_DIV-1 regardless of sequencer state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= {CW{1'b0}};
        end else if (w_tick) begin
            r_cnt <= {CW{1'b0}};
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    // One-step move; TOWARD stops exactly on the target, UP stops at ATT_MAX.
    always_comb begin
        w_att_nxt = r_att;
        if (w_tick) begin
            case (i_mode)
                RAMP_TOWARD: begin
                    if (r_att < i_tgt) begin
                        w_att_nxt = r_att + 5'd1;
                    end else if (r_att > i_tgt) begin
                        w_att_nxt = r_att - 5'd1;
                    end else begin
                        w_att_nxt = r_att;
                    end
                end
                RAMP_UP: begin
                    if (r_att != ATT_MAX) begin
                        w_att_nxt = r_att + 5'd1;
                    end else begin
                        w_att_nxt = r_att;
                    end
                end
                default: w_att_nxt = r_att;
            endcase
        end else begin
            w_att_nxt = r_att;
        end
    end

    // Attenuation register; comes out of reset muted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_att <= ATT_MUTE;
        end else begin
            r_att <= w_att_nxt;
        end
    end
endmodule

// File: rtl/audio_flt_sequencer.sv
// -----------------------------------------------------------------------------
// audio_flt_sequencer
// Click-free control sequencer for the audio filter/mixer datapath. Preset or
// mix changes run FADE_OUT -> LOAD -> SETTLE -> FADE_IN; volume and pause
// changes just ramp attenuation one step per tick while in RUN.
//   clk, reset : filter clock (audio_mclk), synchronous active-high reset
//   bus        : slave side of audio_flt_sequencer_if (requests in, applied
//                coefficients / att / mix / busy / muted out)
// Parameters: RAMP_DIV (cycles per att step), SETTLE_CYC (muted cycles after
// a load), MUTE_PAUSE (pause_core ramps to mute when set).
// -----------------------------------------------------------------------------
module audio_flt_sequencer
    import audio_flt_pkg::*;
#(
    parameter int RAMP_DIV   = 256,
    parameter int SETTLE_CYC = 1024,
    parameter bit MUTE_PAUSE = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    audio_flt_sequencer_if.slave  bus
);
    localparam int            SW          = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    seq_state_t    r_state;
    seq_state_t    w_state_nxt;
    ramp_mode_t    w_mode;
    logic [4:0]    w_tgt;
    logic [4:0]    w_att;
    logic          w_change;
    logic [39:0]   w_fld_val;

    logic [3:0]    r_sw_cur;
    logic [1:0]    r_mix_cur;
    logic          r_latched;     // LOAD latch cycle done, field cycles running
    logic [2:0]    r_fld_idx;
    logic [SW-1:0] r_settle_cnt;
    flt_coef_t     r_coef;
    logic [1:0]    r_mix;
    logic          r_busy;

    assign w_tgt     = (MUTE_PAUSE && bus.pause_core) ? ATT_MUTE : {1'b0, bus.vol_att};
    assign w_change  = (bus.afilter_sw != r_sw_cur) || (bus.mix_sel != r_mix_cur);
    assign w_fld_val = preset_field(r_sw_cur, r_fld_idx);

    att_ramp #(
        .RAMP_DIV (RAMP_DIV)
    ) u_att_ramp (
        .clk    (clk),
        .reset  (reset),
        .i_mode (w_mode),
        .i_tgt  (w_tgt),
        .o_att  (w_att)
    );

    // Next-state and ramp-mode decode; a detected change in RUN beats ramping.
    always_comb begin
        w_state_nxt = r_state;
        w_mode      = RAMP_HOLD;
        case (r_state)
            ST_RUN: begin
                if (w_change) begin
                    w_state_nxt = ST_FADE_OUT;
                end else begin
                    w_mode = RAMP_TOWARD;
                end
            end
            ST_FADE_OUT: begin
                if (w_att[4]) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_mode = RAMP_UP;
                end
            end
            ST_LOAD: begin
                if (r_latched && (r_fld_idx == 3'd7)) begin
                    w_state_nxt = ST_SETTLE;
                end else begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_SETTLE: begin
                if (r_settle_cnt == SETTLE_LAST) begin
                    w_state_nxt = ST_FADE_IN;
                end else begin
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_FADE_IN: begin
                // A muted target (pause) leaves att where it is.
                if (w_tgt[4] || (w_att == w_tgt)) begin
                    w_state_nxt = ST_RUN;
                end else begin
                    w_mode = RAMP_TOWARD;
                end
            end
            default: begin
                w_state_nxt = ST_LOAD;
                w_mode      = RAMP_HOLD;
            end
        endcase
    end

    // State register; busy is registered from the next state so it tracks it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_LOAD;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_RUN);
        end
    end

    // LOAD engine: latch request, then write one field per cycle while muted.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_latched <= 1'b0;
            r_fld_idx <= 3'd0;
            r_sw_cur  <= 4'd0;
            r_mix_cur <= 2'd0;
            r_coef    <= PRESET_0;
            r_mix     <= 2'd0;
        end else if (r_state == ST_LOAD) begin
            if (!r_latched) begin
                r_latched <= 1'b1;
                r_sw_cur  <= bus.afilter_sw;
                r_mix_cur <= bus.mix_sel;
            end else begin
                if (w_att[4]) begin
                    case (r_fld_idx)
                        3'd0:    r_coef.flt_rate <= w_fld_val[31:0];
                        3'd1:    r_coef.cx       <= w_fld_val;
                        3'd2:    r_coef.cx0      <= w_fld_val[7:0];
                        3'd3:    r_coef.cx1      <= w_fld_val[7:0];
                        3'd4:    r_coef.cx2      <= w_fld_val[7:0];
                        3'd5:    r_coef.cy0      <= w_fld_val[23:0];
                        3'd6:    r_coef.cy1      <= w_fld_val[23:0];
                        3'd7:    r_coef.cy2      <= w_fld_val[23:0];
                        default: r_coef          <= r_coef;
                    endcase
                    if (r_fld_idx == 3'd7) begin
                        r_mix <= r_mix_cur;
                    end
                end
                // Index wraps 7 -> 0 ready for the next sequence.
                r_fld_idx <= r_fld_idx + 3'd1;
                if (r_fld_idx == 3'd7) begin
                    r_latched <= 1'b0;
                end
            end
        end
    end

    // Muted settle counter, cleared whenever SETTLE is not active.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_settle_cnt <= {SW{1'b0}};
        end else if ((r_state == ST_SETTLE) && (r_settle_cnt != SETTLE_LAST)) begin
            r_settle_cnt <= r_settle_cnt + SW'(1);
        end else begin
            r_settle_cnt <= {SW{1'b0}};
        end
    end

    assign bus.att      = w_att;
    assign bus.muted    = w_att[4];
    assign bus.busy     = r_busy;
    assign bus.mix      = r_mix;
    assign bus.flt_rate = r_coef.flt_rate;
    assign bus.cx       = r_coef.cx;
    assign bus.cx0      = r_coef.cx0;
    assign bus.cx1      = r_coef.cx1;
    assign bus.cx2      = r_coef.cx2;
    assign bus.cy0      = r_coef.cy0;
    assign bus.cy1      = r_coef.cy1;
    assign bus.cy2      = r_coef.cy2;
endmodule

// File: tb/tb_audio_flt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_audio_flt_sequencer
// Directed, self-checking bench for audio_flt_sequencer with short ramp and
// settle periods. Expected presets and timings are written out by hand below.
// -----------------------------------------------------------------------------
module tb_audio_flt_sequencer;
    localparam int RAMP_DIV   = 8;
    localparam int SETTLE_CYC = 16;
    localparam int BUDGET     = 3000;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    audio_flt_sequencer_if bus();

    audio_flt_sequencer #(
        .RAMP_DIV   (RAMP_DIV),
        .SETTLE_CYC (SETTLE_CYC),
        .MUTE_PAUSE (1'b1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Expected preset table, fields 0 flt_rate .. 7 cy2 (cy as 24-bit two's complement).
    logic [39:0] exp_tbl [4][8] = '{
        '{40'd14112000, 40'd480930, 40'd3, 40'd3, 40'd1, 40'd10523109, 40'd6217090, 40'd14717083},
        '{40'd7056000,  40'd120000, 40'd2, 40'd4, 40'd2, 40'd100,      40'd200,     40'd300},
        '{40'd3528000,  40'd60000,  40'd5, 40'd6, 40'd7, 40'd1000,     40'd2000,    40'd3000},
        '{40'd1764000,  40'd30000,  40'd8, 40'd9, 40'd10, 40'd11,      40'd22,      40'd33}
    };

    typedef struct {
        logic [3:0] sw;
        logic [1:0] mix;
        logic [3:0] vol;
        logic       pause;
        int         preset;
        logic [1:0] exp_mix;
        logic [4:0] exp_att;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [39:0] dut_field(input int f);
        case (f)
            0:       return {8'd0, bus.flt_rate};
            1:       return bus.cx;
            2:       return {32'd0, bus.cx0};
            3:       return {32'd0, bus.cx1};
            4:       return {32'd0, bus.cx2};
            5:       return {16'd0, bus.cy0};
            6:       return {16'd0, bus.cy1};
            default: return {16'd0, bus.cy2};
        endcase
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic check_coefs(input string nm, input int p);
        for (int f = 0; f < 8; f++) begin
            check($sformatf("%s_field%0d", nm, f), dut_field(f), exp_tbl[p][f]);
        end
    endtask

    // Follow att to goal, checking unit steps in the right direction spaced RAMP_DIV apart.
    task automatic watch_att(input string nm, input logic [4:0] goal, input int exp_steps,
                             input int budget, output int busy_cnt);
        int steps;
        int last;
        int bad_gap;
        int bad_step;
        logic [4:0] prev;
        logic [4:0] exp_next;
        steps = 0; last = -1; bad_gap = 0; bad_step = 0; busy_cnt = 0;
        prev = bus.att;
        for (int c = 0; c < budget; c++) begin
            if (bus.att == goal) break;
            @(negedge clk);
            if (bus.busy) busy_cnt++;
            if (bus.att != prev) begin
                exp_next = (goal > prev) ? prev + 5'd1 : prev - 5'd1;
                if (bus.att != exp_next) bad_step++;
                if ((last >= 0) && ((c - last) != RAMP_DIV)) bad_gap++;
                last = c;
                steps++;
                prev = bus.att;
            end
        end
        check({nm, "_att_reached"}, bus.att, goal);
        check({nm, "_step_count"}, steps, exp_steps);
        check({nm, "_bad_gaps"}, bad_gap, 0);
        check({nm, "_bad_steps"}, bad_step, 0);
    endtask

    task automatic wait_idle(input string nm, input logic [4:0] goal);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!((bus.busy == 1'b0) && (bus.att == goal)) && (n < BUDGET));
        check({nm, "_idle_in_time"}, (n < BUDGET), 1);
    endtask

    // Coefficient / mix outputs must never move while att is below mute.
    logic [39:0] mon_prev [8];
    logic [1:0]  mon_prev_mix;
    always @(negedge clk) begin
        for (int f = 0; f < 8; f++) begin
            if (!reset && (dut_field(f) != mon_prev[f])) begin
                checks++;
                if (!bus.muted) begin
                    errors++;
                    $display("FAIL coef_change_unmuted field%0d: att %0d required >= 16", f, bus.att);
                end
            end
            mon_prev[f] <= dut_field(f);
        end
        if (!reset && (bus.mix != mon_prev_mix)) begin
            checks++;
            if (!bus.muted) begin
                errors++;
                $display("FAIL mix_change_unmuted: att %0d required >= 16", bus.att);
            end
        end
        mon_prev_mix <= bus.mix;
    end

    initial begin
        int bc;
        int bad;
        int first [8];
        logic [39:0] pre [8];
        logic found;

        vecs[0] = '{4'd2, 2'd3, 4'd7,  1'b0, 2, 2'd3, 5'd7};
        vecs[1] = '{4'd3, 2'd1, 4'd15, 1'b0, 3, 2'd1, 5'd15};
        vecs[2] = '{4'd9, 2'd1, 4'd15, 1'b0, 0, 2'd1, 5'd15};
        vecs[3] = '{4'd0, 2'd2, 4'd3,  1'b1, 0, 2'd2, 5'd16};
        vecs[4] = '{4'd0, 2'd2, 4'd3,  1'b0, 0, 2'd2, 5'd3};
        vecs[5] = '{4'd1, 2'd0, 4'd0,  1'b0, 1, 2'd0, 5'd0};

        // ---- Reset values and first LOAD -> SETTLE -> FADE_IN ----
        reset = 1'b1;
        bus.afilter_sw = 4'd0; bus.vol_att = 4'd0; bus.mix_sel = 2'd0; bus.pause_core = 1'b0;
        repeat (3) @(negedge clk);
        check_coefs("reset", 0);
        check("reset_att", bus.att, 5'h10);
        check("reset_muted", bus.muted, 1'b1);
        check("reset_busy", bus.busy, 1'b1);
        check("reset_mix", bus.mix, 2'd0);
        reset = 1'b0;
        bad = 0;
        for (int k = 1; k <= 9 + SETTLE_CYC; k++) begin
            @(negedge clk);
            if ((bus.att != 5'h10) || (bus.busy != 1'b1)) bad++;
        end
        check("boot_held_muted_cycles", bad, 0);
        check_coefs("boot", 0);
        watch_att("boot_fade_in", 5'd0, 16, 16 * RAMP_DIV + 4 * RAMP_DIV, bc);
        check("boot_busy_at_att0", bus.busy, 1'b1);
        @(negedge clk);
        check("boot_busy_after", bus.busy, 1'b0);

        // ---- Preset 0 -> 1: fade out 16 ticks, fields written in order ----
        bus.afilter_sw = 4'd1;
        watch_att("p1_fade_out", 5'h10, 16, 16 * RAMP_DIV + 4 * RAMP_DIV, bc);
        for (int f = 0; f < 8; f++) begin
            first[f] = -1;
            pre[f] = dut_field(f);
        end
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            for (int f = 0; f < 8; f++) begin
                if ((first[f] < 0) && (dut_field(f) != pre[f])) first[f] = c;
            end
        end
        check("p1_field0_cycle", first[0], 2);
        for (int f = 1; f < 8; f++) begin
            check($sformatf("p1_field%0d_offset", f), first[f] - first[0], f);
        end
        wait_idle("p1", 5'd0);
        check_coefs("p1", 1);

        // ---- Table-driven request changes ----
        for (int i = 0; i < 6; i++) begin
            bus.afilter_sw = vecs[i].sw;
            bus.mix_sel    = vecs[i].mix;
            bus.vol_att    = vecs[i].vol;
            bus.pause_core = vecs[i].pause;
            wait_idle($sformatf("vec%0d", i), vecs[i].exp_att);
            check_coefs($sformatf("vec%0d", i), vecs[i].preset);
            check($sformatf("vec%0d_mix", i), bus.mix, vecs[i].exp_mix);
            check($sformatf("vec%0d_att", i), bus.att, vecs[i].exp_att);
            check($sformatf("vec%0d_muted", i), bus.muted, vecs[i].exp_att[4]);
            repeat (3 * RAMP_DIV) @(negedge clk);
            check($sformatf("vec%0d_no_retrigger", i), bus.busy, 1'b0);
            check($sformatf("vec%0d_att_stable", i), bus.att, vecs[i].exp_att);
        end

        // ---- Volume 0 -> 5 in RUN: five steps, never busy ----
        bus.vol_att = 4'd5;
        watch_att("vol5", 5'd5, 5, 8 * RAMP_DIV, bc);
        check("vol5_busy_cycles", bc, 0);

        // ---- Reset while LOAD writes field 4 ----
        bus.afilter_sw = 4'd2;
        found = 1'b0;
        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            if (bus.flt_rate != 32'd7056000) begin
                found = 1'b1;
                break;
            end
        end
        check("midload_field0_seen", found, 1'b1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_coefs("midload_reset", 0);
        check("midload_reset_att", bus.att, 5'h10);
        check("midload_reset_busy", bus.busy, 1'b1);
        check("midload_reset_mix", bus.mix, 2'd0);
        reset = 1'b0;
        repeat (9) @(negedge clk);
        check_coefs("midload_restart", 2);
        check("midload_restart_att", bus.att, 5'h10);
        wait_idle("midload", 5'd5);
        check("midload_final_att", bus.att, 5'd5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
